// File: rtl/apb_master_pkg.sv
// Shared types and sizing helpers for the APB command master.
package apb_master_pkg;

    localparam int unsigned APB_ADDR_W      = 12;
    localparam int unsigned APB_DATA_W      = 32;
    localparam int unsigned APB_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    // Wait-counter width able to hold TIMEOUT_CYC; at least one bit so a
    // disabled timeout still yields a legal vector.
    function automatic int unsigned wait_cnt_w(input int unsigned timeout_cyc);
        int unsigned w;
        w = $clog2(timeout_cyc + 1);
        return (w == 0) ? 1 : w;
    endfunction

    localparam int unsigned APB_WAIT_CNT_W = wait_cnt_w(APB_TIMEOUT_CYC);

endpackage

// File: rtl/apb_wait_timeout.sv
// Counts ACCESS cycles spent waiting on pready and flags the cycle that
// would make the count reach the timeout limit.
module apb_wait_timeout
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC,
    parameter int unsigned CNT_W       = wait_cnt_w(TIMEOUT_CYC)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    localparam int unsigned LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    logic [CNT_W-1:0] r_cnt;

    // Wait counter: cleared on reset and on each new transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // This waiting cycle is the one that brings the count to TIMEOUT_CYC.
    assign o_expired_c = (TIMEOUT_CYC != 0) && i_en && (r_cnt == CNT_W'(LAST));

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: turns a command/response stream into APB SETUP/ACCESS
// transfers with wait-state and timeout handling, plus a sticky IRQ flag.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              interrupt,
    output logic              irq_pending,
    input  logic              irq_clr
);

    apb_mst_state_e    r_state;
    apb_mst_state_e    w_state_nxt;
    apb_cmd_t          r_cmd;
    apb_cmd_t          w_cmd_nxt;
    apb_cmd_t          w_cmd_in;
    logic              r_psel;
    logic              w_psel_nxt;
    logic              r_penable;
    logic              w_penable_nxt;
    logic              r_rsp_valid;
    logic              w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              r_rsp_err;
    logic              w_rsp_err_nxt;
    logic              r_irq_q;
    logic              r_irq_pending;
    logic              w_irq_pending_nxt;
    logic              w_accept;
    logic              w_wait_en;
    logic              w_expired_c;

    // Commands are taken only from IDLE and never while reset is held.
    assign cmd_ready = (r_state == IDLE) && !preset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cmd_in  = '{write: cmd_write,
                         addr:  APB_ADDR_W'(cmd_addr),
                         wdata: APB_DATA_W'(cmd_wdata)};

    // A waiting cycle is an ACCESS cycle without pready.
    assign w_wait_en = (r_state == ACCESS) && !pready;

    // Wait-state counter and timeout detect.
    apb_wait_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timeout (
        .i_clk       (pclk),
        .i_rst       (preset),
        .i_clr       (w_accept),
        .i_en        (w_wait_en),
        .o_expired_c (w_expired_c)
    );

    // Next-state and next-output decode for the transfer FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = SETUP;
                    w_cmd_nxt     = w_cmd_in;
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                end
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    w_state_nxt     = RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_cmd.write ? '0 : prdata;
                    w_rsp_err_nxt   = 1'b0;
                end else if (w_expired_c) begin
                    w_state_nxt     = RESP;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Rising edge of interrupt sets the flag; a coincident clear loses.
    assign w_irq_pending_nxt = (interrupt && !r_irq_q) || (r_irq_pending && !irq_clr);

    // State and output registers.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= IDLE;
            r_cmd         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_irq_q       <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd         <= w_cmd_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_irq_q       <= interrupt;
            r_irq_pending <= w_irq_pending_nxt;
        end
    end

    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_cmd.write;
    assign paddr       = ADDR_W'(r_cmd.addr);
    assign pwdata      = DATA_W'(r_cmd.wdata);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign irq_pending = r_irq_pending;

endmodule
